// File: rtl/direction_queue_if.sv
// Signal bundle between the board-side button conditioner and its consumers.
// The count width follows the queue depth so both ends agree on it.
interface direction_queue_if #(
  parameter int unsigned QUEUE_DEPTH = 2
);
  localparam int unsigned CountW = $clog2(QUEUE_DEPTH + 1);

  logic [3:0]        pb_i;
  logic              tick_i;
  logic              game_rst_i;
  logic [3:0]        dir_o;
  logic [3:0]        press_pulse_o;
  logic [CountW-1:0] count_o;

  modport master (
    output pb_i,
    output tick_i,
    output game_rst_i,
    input  dir_o,
    input  press_pulse_o,
    input  count_o
  );

  modport slave (
    input  pb_i,
    input  tick_i,
    input  game_rst_i,
    output dir_o,
    output press_pulse_o,
    output count_o
  );
endinterface

// File: rtl/direction_queue.sv
// Pushbutton synchroniser/debouncer feeding a small turn FIFO that releases one
// accepted direction per game tick, rejecting duplicates and reversals.
module direction_queue #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned QUEUE_DEPTH     = 2
) (
  input  logic             clk,
  input  logic             nrst,
  direction_queue_if.slave bus
);

  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned CountW = $clog2(QUEUE_DEPTH + 1);

  localparam logic [3:0]        DirRight  = 4'b0010;
  localparam logic [DbW-1:0]    DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CountW-1:0] CountFull = CountW'(QUEUE_DEPTH);

  // Bit order everywhere is {up, down, right, left}.
  function automatic logic [3:0] opposite(input logic [3:0] d);
    return {d[2], d[3], d[0], d[1]};
  endfunction

  logic [3:0]        sync1_q, sync_q;
  logic [3:0]        stable_q, stable_d, stable_dly_q;
  logic [DbW-1:0]    db_cnt_q [4];
  logic [DbW-1:0]    db_cnt_d [4];
  logic [3:0]        pulse;

  logic [3:0]        cand;
  logic              cand_valid;
  logic              pop, push, room;
  logic [CountW-1:0] count_after_pop;

  logic [3:0]        mem_q [QUEUE_DEPTH];
  logic [3:0]        mem_d [QUEUE_DEPTH];
  logic [CountW-1:0] count_q, count_d;
  logic [3:0]        dir_q, dir_d;
  logic [3:0]        last_dir_q, last_dir_d;

  // Two-flop synchroniser for the asynchronous pins.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q <= '0;
      sync_q  <= '0;
    end else begin
      sync1_q <= bus.pb_i;
      sync_q  <= sync1_q;
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (sync_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          stable_d[i] = sync_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stable_q     <= '0;
      stable_dly_q <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  assign pulse = stable_q & ~stable_dly_q;

  always_comb begin
    cand = '0;
    if (pulse[3]) begin
      cand = 4'b1000;
    end else if (pulse[2]) begin
      cand = 4'b0100;
    end else if (pulse[1]) begin
      cand = 4'b0010;
    end else if (pulse[0]) begin
      cand = 4'b0001;
    end
  end

  assign cand_valid = |pulse;

  // Pop is resolved before push, so a full queue ticking this cycle still has room.
  assign pop             = bus.tick_i && (count_q != '0);
  assign count_after_pop = count_q - CountW'(pop);
  assign room            = count_after_pop < CountFull;
  assign push            = cand_valid && !bus.game_rst_i && room &&
                           (cand != last_dir_q) && (cand != opposite(last_dir_q));

  always_comb begin
    mem_d      = mem_q;
    count_d    = count_q;
    dir_d      = dir_q;
    last_dir_d = last_dir_q;
    if (bus.game_rst_i) begin
      count_d    = '0;
      dir_d      = DirRight;
      last_dir_d = DirRight;
    end else begin
      if (pop) begin
        dir_d = mem_q[0];
        for (int i = 0; i < int'(QUEUE_DEPTH) - 1; i++) begin
          mem_d[i] = mem_q[i + 1];
        end
      end
      if (push) begin
        for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
          if (CountW'(i) == count_after_pop) begin
            mem_d[i] = cand;
          end
        end
        last_dir_d = cand;
      end
      count_d = count_after_pop + CountW'(push);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q    <= '0;
      dir_q      <= DirRight;
      last_dir_q <= DirRight;
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q    <= count_d;
      dir_q      <= dir_d;
      last_dir_q <= last_dir_d;
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign bus.dir_o         = dir_q;
  assign bus.press_pulse_o = pulse;
  assign bus.count_o       = count_q;

endmodule

// File: tb/tb_direction_queue.sv
// Directed bench for direction_queue with a short debounce window; inputs are
// driven and outputs sampled on the falling clock edge.
module tb_direction_queue;

  localparam int unsigned Db    = 4;
  localparam int unsigned Depth = 2;

  logic clk;
  logic nrst;
  int   vectors;
  int   miscompares;

  direction_queue_if #(.QUEUE_DEPTH(Depth)) bus ();

  direction_queue #(
    .DEBOUNCE_CYCLES(Db),
    .QUEUE_DEPTH    (Depth)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick_once();
    bus.tick_i = 1'b1;
    @(negedge clk);
    bus.tick_i = 1'b0;
  endtask

  task automatic game_restart();
    bus.game_rst_i = 1'b1;
    @(negedge clk);
    bus.game_rst_i = 1'b0;
  endtask

  // Press, wait until the queue has reacted, then release and let the release settle.
  task automatic tap(input logic [3:0] mask);
    bus.pb_i = mask;
    repeat (7) @(negedge clk);
    bus.pb_i = 4'b0000;
    repeat (8) @(negedge clk);
  endtask

  // Returns inside the pulse cycle so the caller can add tick/game_rst to it.
  task automatic press_hold(input logic [3:0] mask, input string tag);
    bus.pb_i = mask;
    repeat (6) @(negedge clk);
    chk(tag, 32'(bus.press_pulse_o), 32'(mask));
  endtask

  task automatic release_pb();
    bus.pb_i = 4'b0000;
    repeat (8) @(negedge clk);
  endtask

  // Pin is driven between edges 0 and 1; sync settles at edge 2, stable at
  // edge 2+Db, so the pulse occupies the cycle ending at edge 7 and count follows.
  task automatic measure_press(input logic [3:0] mask, input string tag);
    int         first;
    int         n_pulse;
    logic [3:0] seen;
    first   = 0;
    n_pulse = 0;
    seen    = '0;
    bus.pb_i = mask;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (bus.press_pulse_o != 4'b0000) begin
        n_pulse++;
        if (first == 0) begin
          first = n;
          seen  = bus.press_pulse_o;
        end
      end
    end
    chk({tag, "_pulse_edge"}, 32'(first), 32'(2 + Db));
    chk({tag, "_pulse_cycles"}, 32'(n_pulse), 32'd1);
    chk({tag, "_pulse_value"}, 32'(seen), 32'(mask));
    chk({tag, "_count"}, 32'(bus.count_o), 32'd1);
  endtask

  initial begin
    logic any_pulse;
    vectors        = 0;
    miscompares    = 0;
    nrst           = 1'b0;
    bus.pb_i       = 4'b0000;
    bus.tick_i     = 1'b0;
    bus.game_rst_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dir", 32'(bus.dir_o), 32'h2);
    chk("rst_count", 32'(bus.count_o), 32'd0);
    chk("rst_pulse", 32'(bus.press_pulse_o), 32'h0);
    nrst = 1'b1;
    @(negedge clk);

    // Single press latency, then one tick moves it to the direction output.
    measure_press(4'b1000, "up");
    chk("up_dir_before_tick", 32'(bus.dir_o), 32'h2);
    release_pb();
    tick_once();
    chk("up_tick_dir", 32'(bus.dir_o), 32'h8);
    chk("up_tick_count", 32'(bus.count_o), 32'd0);

    // Bounce shorter than the debounce window never produces a pulse.
    game_restart();
    any_pulse = 1'b0;
    for (int c = 0; c < 20; c++) begin
      bus.pb_i = {2'b00, ((c / 2) % 2) == 0, 1'b0};
      @(negedge clk);
      if (bus.press_pulse_o != 4'b0000) any_pulse = 1'b1;
    end
    bus.pb_i = 4'b0000;
    repeat (10) begin
      @(negedge clk);
      if (bus.press_pulse_o != 4'b0000) any_pulse = 1'b1;
    end
    chk("bounce_pulse", 32'(any_pulse), 32'd0);
    chk("bounce_count", 32'(bus.count_o), 32'd0);
    chk("bounce_dir", 32'(bus.dir_o), 32'h2);

    // Reversal and duplicate rejection starting from right.
    tap(4'b0001);
    chk("rev_left", 32'(bus.count_o), 32'd0);
    tap(4'b0010);
    chk("dup_right", 32'(bus.count_o), 32'd0);
    tap(4'b1000);
    chk("acc_up", 32'(bus.count_o), 32'd1);
    tap(4'b0100);
    chk("rev_down", 32'(bus.count_o), 32'd1);

    // Double-tap fills the queue; third turn is dropped.
    game_restart();
    tap(4'b1000);
    tap(4'b0001);
    tap(4'b0100);
    chk("ovf_count", 32'(bus.count_o), 32'd2);
    tick_once();
    chk("ovf_tick1_dir", 32'(bus.dir_o), 32'h8);
    chk("ovf_tick1_count", 32'(bus.count_o), 32'd1);
    tick_once();
    chk("ovf_tick2_dir", 32'(bus.dir_o), 32'h1);
    tick_once();
    chk("ovf_tick3_dir", 32'(bus.dir_o), 32'h1);
    chk("ovf_tick3_count", 32'(bus.count_o), 32'd0);

    // Up and left pulse together: only up is queued.
    game_restart();
    press_hold(4'b1001, "multi_pulse");
    release_pb();
    chk("multi_count", 32'(bus.count_o), 32'd1);
    tick_once();
    chk("multi_dir", 32'(bus.dir_o), 32'h8);
    chk("multi_count_after", 32'(bus.count_o), 32'd0);

    // Full queue with tick and a valid press in the same cycle.
    game_restart();
    tap(4'b1000);
    tap(4'b0001);
    press_hold(4'b1000, "full_pulse");
    tick_once();
    chk("full_pp_count", 32'(bus.count_o), 32'd2);
    chk("full_pp_dir", 32'(bus.dir_o), 32'h8);
    release_pb();
    tick_once();
    chk("full_pp_head", 32'(bus.dir_o), 32'h1);
    tick_once();
    chk("full_pp_tail", 32'(bus.dir_o), 32'h8);
    chk("full_pp_empty", 32'(bus.count_o), 32'd0);

    // Empty queue with push and tick together: the push is not popped yet.
    game_restart();
    press_hold(4'b1000, "empty_pulse");
    tick_once();
    chk("empty_pp_count", 32'(bus.count_o), 32'd1);
    chk("empty_pp_dir", 32'(bus.dir_o), 32'h2);
    release_pb();
    tick_once();
    chk("empty_pp_pop", 32'(bus.dir_o), 32'h8);

    // Game restart wins over a simultaneous press and restores last_dir=right.
    tap(4'b0001);
    press_hold(4'b0100, "grst_pulse");
    game_restart();
    chk("grst_count", 32'(bus.count_o), 32'd0);
    chk("grst_dir", 32'(bus.dir_o), 32'h2);
    release_pb();
    tap(4'b0001);
    chk("grst_last_right", 32'(bus.count_o), 32'd0);

    // Asynchronous reset mid-debounce with one queued entry.
    game_restart();
    tap(4'b1000);
    chk("nrst_pre_count", 32'(bus.count_o), 32'd1);
    bus.pb_i = 4'b0001;
    repeat (3) @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("nrst_dir", 32'(bus.dir_o), 32'h2);
    chk("nrst_count", 32'(bus.count_o), 32'd0);
    chk("nrst_pulse", 32'(bus.press_pulse_o), 32'h0);
    @(negedge clk);
    bus.pb_i = 4'b0000;
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    measure_press(4'b1000, "post_rst");
    release_pb();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
